// File: rtl/stream_xor_encryptor.sv
// ============================================================================
//  Module      : stream_xor_encryptor
//  Description : Handshaked byte encryptor; XORs plaintext with an 8-bit LFSR
//                keystream that restarts from the loaded key at every packet.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_xor_encryptor #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_load,
  input  logic [DATA_W-1:0] key_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_NOKEY = 2'd0,
    S_IDLE  = 2'd1,
    S_PKT   = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] c_seed_one = DATA_W'(1);

  state_t            r_state;
  logic [DATA_W-1:0] r_seed;
  logic [DATA_W-1:0] r_pend_key;
  logic              r_pend_v;
  logic [DATA_W-1:0] r_ks;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic              r_out_valid;

  logic              w_accept;
  logic [DATA_W-1:0] w_key_seed;
  logic [DATA_W-1:0] w_ks_next;
  logic              w_pend_v_eff;
  logic [DATA_W-1:0] w_pend_key_eff;

  // An all-zero LFSR would lock up, so a zero key maps to 1.
  assign w_key_seed = (key_in == '0) ? c_seed_one : key_in;
  assign w_ks_next  = {r_ks[6:0], r_ks[7] ^ r_ks[5] ^ r_ks[4] ^ r_ks[3]};

  // A strobe arriving on the very edge a key is applied still wins.
  assign w_pend_v_eff   = r_pend_v | key_load;
  assign w_pend_key_eff = key_load ? w_key_seed : r_pend_key;

  assign in_ready  = (r_state != S_NOKEY) && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = (r_state == S_PKT) || r_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_NOKEY;
      r_seed      <= c_seed_one;
      r_pend_key  <= '0;
      r_pend_v    <= 1'b0;
      r_ks        <= c_seed_one;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_data  <= in_data ^ r_ks;
        r_out_last  <= in_last;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        S_NOKEY: begin
          if (key_load) begin
            r_seed  <= w_key_seed;
            r_ks    <= w_key_seed;
            r_state <= S_IDLE;
          end
        end
        default: begin
          if (key_load) begin
            r_pend_key <= w_key_seed;
            r_pend_v   <= 1'b1;
          end
          if (w_accept && !in_last) begin
            r_ks    <= w_ks_next;
            r_state <= S_PKT;
          end else if (w_accept || (r_state == S_IDLE)) begin
            // Packet boundary: the only place a new key may take effect.
            r_state <= S_IDLE;
            if (w_pend_v_eff) begin
              r_seed   <= w_pend_key_eff;
              r_ks     <= w_pend_key_eff;
              r_pend_v <= 1'b0;
            end else if (w_accept) begin
              r_ks <= r_seed;
            end
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_xor_encryptor.sv
// ============================================================================
//  Module      : tb_stream_xor_encryptor
//  Description : Directed bench with a per-packet keystream model and literal
//                expectations for stream_xor_encryptor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_xor_encryptor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_load;
  logic [7:0] key_in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  always #5 clk = ~clk;

  stream_xor_encryptor #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (key_load),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: a packet's n-th byte is XORed with the seed stepped n times.
  logic [8:0] exp_q[$];
  logic [7:0] cap_d[$];
  logic       cap_l[$];
  logic [8:0] e_cmp;
  bit         m_has_key;
  logic [7:0] m_seed;
  logic [7:0] m_pend;
  bit         m_pend_v;
  int         m_idx;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [7:0] ks_at(input logic [7:0] seed, input int n);
    logic [7:0] s;
    s = seed;
    for (int i = 0; i < n; i++) s = lfsr_step(s);
    return s;
  endfunction

  function automatic logic [7:0] fix_key(input logic [7:0] k);
    return (k == 8'h00) ? 8'h01 : k;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      cap_d.push_back(out_data);
      cap_l.push_back(out_last);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_unexpected: got %0h with no byte outstanding", out_data);
      end else begin
        e_cmp = exp_q.pop_front();
        check("out_data", {24'h0, out_data}, {24'h0, e_cmp[7:0]});
        check("out_last", {31'h0, out_last}, {31'h0, e_cmp[8]});
      end
    end
  end

  task automatic model_reset();
    exp_q.delete();
    m_has_key = 0;
    m_seed    = 8'h01;
    m_pend_v  = 0;
    m_idx     = 0;
  endtask

  // Callers start just after a rising edge; returns just after a rising edge.
  task automatic send(input logic [7:0] d, input logic last);
    int  n;
    bit  ok;
    n  = 0;
    ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1;
      else n++;
    end
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      return;
    end
    exp_q.push_back({last, d ^ ks_at(m_seed, m_idx)});
    if (last) begin
      m_idx = 0;
      if (m_pend_v) begin
        m_seed   = m_pend;
        m_pend_v = 0;
      end
    end else begin
      m_idx++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("latency_valid", {31'h0, out_valid}, 32'd1);
  endtask

  task automatic load_key(input logic [7:0] k);
    key_in   = k;
    key_load = 1'b1;
    if (!m_has_key) begin
      m_seed    = fix_key(k);
      m_idx     = 0;
      m_has_key = 1;
    end else if (m_idx == 0) begin
      m_seed = fix_key(k);
    end else begin
      m_pend   = fix_key(k);
      m_pend_v = 1;
    end
    @(posedge clk);
    #1 key_load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_d.delete();
    cap_l.delete();
  endtask

  task automatic check_cap(input string nm, input int i, input logic [7:0] d, input logic l);
    if (i >= cap_d.size()) begin
      check({nm, "_missing"}, cap_d.size(), i + 1);
    end else begin
      check({nm, "_data"}, {24'h0, cap_d[i]}, {24'h0, d});
      check({nm, "_last"}, {31'h0, cap_l[i]}, {31'h0, l});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    key_load  = 1'b0;
    key_in    = 8'h00;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    model_reset();

    idle(2);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_out_data",  {24'h0, out_data},  32'd0);
    check("rst_out_last",  {31'h0, out_last},  32'd0);
    check("rst_in_ready",  {31'h0, in_ready},  32'd0);
    check("rst_busy",      {31'h0, busy},      32'd0);
    rst_n = 1'b1;
    idle(1);
    check("nokey_in_ready", {31'h0, in_ready}, 32'd0);

    // Basic stream
    clear_cap();
    load_key(8'hAA);
    check("key_in_ready", {31'h0, in_ready}, 32'd1);
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b1);
    idle(2);
    check_cap("basic0", 0, 8'h55, 1'b0);
    check_cap("basic1", 1, 8'hAA, 1'b0);
    check_cap("basic2", 2, 8'h54, 1'b1);

    // Keystream restart per packet
    clear_cap();
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b1);
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b1);
    idle(2);
    check_cap("restart0", 0, 8'h55, 1'b0);
    check_cap("restart1", 1, 8'hAA, 1'b1);
    check_cap("restart2", 2, 8'h55, 1'b0);
    check_cap("restart3", 3, 8'hAA, 1'b1);

    // Zero key maps to seed 1
    clear_cap();
    load_key(8'h00);
    send(8'h00, 1'b0);
    send(8'h00, 1'b1);
    idle(2);
    check_cap("zero0", 0, 8'h01, 1'b0);
    check_cap("zero1", 1, 8'h02, 1'b1);

    // Key load mid-packet defers to the boundary
    clear_cap();
    load_key(8'hAA);
    send(8'hFF, 1'b0);
    idle(2);
    check("pkt_busy", {31'h0, busy}, 32'd1);
    load_key(8'h0F);
    idle(1);
    send(8'hFF, 1'b1);
    send(8'hF0, 1'b1);
    idle(2);
    check("idle_busy", {31'h0, busy}, 32'd0);
    check_cap("midkey0", 0, 8'h55, 1'b0);
    check_cap("midkey1", 1, 8'hAA, 1'b1);
    check_cap("midkey2", 2, 8'hFF, 1'b1);

    // Backpressure
    clear_cap();
    load_key(8'hAA);
    out_ready = 1'b0;
    send(8'hFF, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready",  {31'h0, in_ready},  32'd0);
      check("bp_out_valid", {31'h0, out_valid}, 32'd1);
      check("bp_out_data",  {24'h0, out_data},  32'h55);
      check("bp_busy",      {31'h0, busy},      32'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b1);
    idle(2);
    check_cap("bp0", 0, 8'h55, 1'b0);
    check_cap("bp1", 1, 8'hAA, 1'b0);
    check_cap("bp2", 2, 8'h54, 1'b1);

    // Asynchronous reset mid-packet
    clear_cap();
    send(8'hFF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'h0, out_valid}, 32'd0);
    check("arst_out_data",  {24'h0, out_data},  32'd0);
    check("arst_out_last",  {31'h0, out_last},  32'd0);
    check("arst_in_ready",  {31'h0, in_ready},  32'd0);
    check("arst_busy",      {31'h0, busy},      32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h12;
    in_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("arst_nokey_ready", {31'h0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    load_key(8'h3C);
    check("rekey_in_ready", {31'h0, in_ready}, 32'd1);
    send(8'h12, 1'b1);
    idle(2);
    check_cap("rekey0", 0, 8'h2E, 1'b1);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
